mem_port_sched: RTL
===================

# mem_port_sched

- Single-port memory scheduler for the 6502-style core.
- Shares one memory port between two requesters:
  - the instruction-fetch side of the main FSM (load, store, ADDI, ADD, BEQ sequencing);
  - the execute-side data access (LOAD/STORE operand, ADD memory operand).
- Data accesses have priority, with a fairness guard so fetch cannot starve.
- Sits between the main control FSM and the memory interface that feeds `in_mem`.

## Interface
Parameters:
- MEM_LAT, 2, cycles `out_mem_en` is held before `in_mem` is sampled; legal 1..15
- STREAK_MAX, 3, maximum consecutive data grants while fetch is pending; legal 1..7

Ports:
- in_clka  input  1  sole clock; all state updates on rising edge
- in_restart  input  1  reset, synchronous, active-high
- in_fetch_req  input  1  fetch request, level, held until ack
- in_fetch_addr  input  8  fetch address
- out_fetch_ack  output  1  one-cycle pulse; fetch read complete
- out_fetch_data  output  8  fetched byte, held until next fetch ack
- in_data_req  input  1  data request, level, held until ack
- in_data_we  input  1  1 = write, 0 = read
- in_data_addr  input  8  data address
- in_data_wdata  input  8  write data
- out_data_ack  output  1  one-cycle pulse; data access complete
- out_data_rdata  output  8  read byte, held until next data read ack
- out_mem_en  output  1  memory access active
- out_mem_we  output  1  memory write strobe, valid with `out_mem_en`
- out_mem_addr  output  8  memory address
- out_mem_wdata  output  8  memory write data
- in_mem  input  8  memory read data
- out_state_arb  output  2  current state encoding

## Operation
- States: IDLE=0, ACCESS=1, RESP=2; encoding 3 is unused and returns to IDLE.
- IDLE:
  - No request pending: stay in IDLE.
  - Only one request pending: grant it.
  - Both pending: data wins unless streak == STREAK_MAX, in which case fetch wins.
  - On grant: latch owner, addr, wdata, we; load latency counter with MEM_LAT-1; go to ACCESS.
- ACCESS:
  - `out_mem_en`=1; addr, wdata and we driven from latches. Fetch is always a read (we=0).
  - Requester input changes after grant are ignored.
  - Counter decrements each cycle. At 0: on a read, capture `in_mem` into the owner's data register; go to RESP.
- RESP:
  - Owner's ack = 1 for exactly one cycle; `out_mem_en`=0; next state IDLE.
  - The requester must have req low in the following IDLE cycle; a req still high there is a new request.
- Streak counter (3 bits):
  - +1 on a data grant while fetch req is high, saturating at STREAK_MAX.
  - Cleared on a fetch grant, and on a data grant with fetch req low.
- Writes never modify `out_data_rdata`.
- Reset value of every output is 0, including data registers, streak and state.
- Reset mid-operation (any state): next cycle is IDLE, no ack issued, `out_mem_en`=0. An aborted write may or may not have committed; the requester reissues.
- Simultaneous `in_restart` and requests: reset wins; requests are re-evaluated in the first post-reset IDLE cycle.

## Timing
- Request high in IDLE cycle N gives:
  - ACCESS in cycles N+1..N+MEM_LAT;
  - `in_mem` sampled at the edge ending cycle N+MEM_LAT;
  - ack in cycle N+MEM_LAT+1.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- `out_mem_*` are registered and change only on state entry/exit.
- `out_fetch_data` and `out_data_rdata` are valid from the ack cycle onward.

## Configuration
- MEM_PORT_SCHED_STALL_CNT_EN defined:
  - Adds output port `out_stall_cnt` [15:0].
  - Counts cycles in which `in_fetch_req`=1 and the scheduler is not in ACCESS/RESP for a fetch.
  - Saturates at 16'hFFFF; cleared by `in_restart`.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: `in_restart`=1 for 2 cycles with both reqs high -> all outputs 0 and `out_state_arb`=0 during reset; first grant in the cycle after release.
- Fetch read, MEM_LAT=2: req at cycle 0, addr 8'h10, `in_mem`=8'hA5 -> `out_mem_en`=1 in cycles 1–2 with addr 8'h10; `out_fetch_ack` in cycle 3; `out_fetch_data`=8'hA5.
- Data write: addr 8'h20, wdata 8'h3C -> `out_mem_we`=1, addr 8'h20, wdata 8'h3C for 2 cycles; `out_data_ack` in cycle 3; `out_data_rdata` unchanged from 8'h00.
- Fairness, STREAK_MAX=3: both reqs re-asserted continuously after each ack -> grant order D, D, D, F, D, D, D, F.
- Reset mid-ACCESS: assert `in_restart` in the first ACCESS cycle -> next cycle IDLE, `out_mem_en`=0, no ack pulses; reissued req completes normally.
- With MEM_PORT_SCHED_STALL_CNT_EN: fetch and data asserted together at cycle 0 with MEM_LAT=2 -> `out_stall_cnt`=5 when the fetch is granted.

Source files
------------

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler: arbitrates fetch vs. data requests onto one memory port.
// Optional MEM_PORT_SCHED_STALL_CNT_EN adds out_stall_cnt (fetch stall cycle counter).
module mem_port_sched #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STREAK_MAX = 3
) (
  input  logic       in_clka,
  input  logic       in_restart,
  input  logic       in_fetch_req,
  input  logic [7:0] in_fetch_addr,
  output logic       out_fetch_ack,
  output logic [7:0] out_fetch_data,
  input  logic       in_data_req,
  input  logic       in_data_we,
  input  logic [7:0] in_data_addr,
  input  logic [7:0] in_data_wdata,
  output logic       out_data_ack,
  output logic [7:0] out_data_rdata,
  output logic       out_mem_en,
  output logic       out_mem_we,
  output logic [7:0] out_mem_addr,
  output logic [7:0] out_mem_wdata,
  input  logic [7:0] in_mem,
  output logic [1:0] out_state_arb
`ifdef MEM_PORT_SCHED_STALL_CNT_EN
  ,
  output logic [15:0] out_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    UNUSED = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [2:0] STREAK_LIM = 3'(STREAK_MAX);

  state_t     state;
  logic [3:0] lat_cnt;
  logic [2:0] streak;
  logic       owner_fetch;
  logic       grant_fetch;

  // Data has priority unless fetch has been passed over STREAK_MAX times in a row.
  always_comb begin
    grant_fetch = in_fetch_req && (!in_data_req || (streak == STREAK_LIM));
  end

  assign out_state_arb = state;

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      streak         <= '0;
      owner_fetch    <= 1'b0;
      out_fetch_ack  <= 1'b0;
      out_fetch_data <= '0;
      out_data_ack   <= 1'b0;
      out_data_rdata <= '0;
      out_mem_en     <= 1'b0;
      out_mem_we     <= 1'b0;
      out_mem_addr   <= '0;
      out_mem_wdata  <= '0;
    end else begin
      out_fetch_ack <= 1'b0;
      out_data_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_fetch_req || in_data_req) begin
            state         <= ACCESS;
            owner_fetch   <= grant_fetch;
            lat_cnt       <= LAT_INIT;
            out_mem_en    <= 1'b1;
            out_mem_addr  <= grant_fetch ? in_fetch_addr : in_data_addr;
            out_mem_wdata <= grant_fetch ? '0 : in_data_wdata;
            out_mem_we    <= !grant_fetch && in_data_we;
            if (grant_fetch || !in_fetch_req)
              streak <= '0;
            else if (streak >= STREAK_LIM)
              streak <= STREAK_LIM;
            else
              streak <= streak + 3'd1;
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd0) begin
            state         <= RESP;
            out_mem_en    <= 1'b0;
            out_mem_we    <= 1'b0;
            out_mem_addr  <= '0;
            out_mem_wdata <= '0;
            // The registered memory outputs double as the granted request latches.
            if (owner_fetch) begin
              out_fetch_data <= in_mem;
              out_fetch_ack  <= 1'b1;
            end else begin
              if (!out_mem_we)
                out_data_rdata <= in_mem;
              out_data_ack <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_SCHED_STALL_CNT_EN
  always_ff @(posedge in_clka) begin
    if (in_restart)
      out_stall_cnt <= '0;
    else if (in_fetch_req && !(((state == ACCESS) || (state == RESP)) && owner_fetch)
             && (out_stall_cnt != 16'hFFFF))
      out_stall_cnt <= out_stall_cnt + 16'd1;
  end
`endif

endmodule
